reduceron_io_uart: RTL and testbench
====================================

Name: reduceron_io_uart

Overview:
- Downstream consumer of the Reduceron core's IO-write port and finish/result outputs.
- Captures IO writes addressed to a character-output address into a small FIFO and serialises them as 8N1 UART bytes on a single pin.
- Latches the final result on `finish` and raises `done` once all queued output has left the wire.
- Replaces the simulation-only `$display` sink, so the core can run on the FPGA board with a serial console.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (100 MHz / 230400 baud); minimum 2.
- FIFO_LOG2, 4, log2 of FIFO depth (depth = 16 bytes).
- PUTCHAR_ADDR, 15'd0, IO address whose writes are forwarded as characters.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- iowrite  in  1  core IO write strobe, one cycle per write.
- ioaddr  in  15  IO write address.
- iowd  in  15  IO write data; bits [7:0] form the character.
- finish  in  1  core has finished; result is valid this cycle.
- result  in  18  core result word; payload = result[17:3], tag = result[2:0].
- uart_tx  out  1  serial output, idle high.
- tx_busy  out  1  FIFO non-empty or transmitter not idle.
- overflow  out  1  sticky: at least one character was dropped on a full FIFO.
- dropped  out  8  count of dropped characters, saturates at 255.
- other_writes  out  8  count of IO writes to addresses other than PUTCHAR_ADDR, saturates at 255.
- done  out  1  finish latched, FIFO empty and transmitter idle.
- result_value  out  15  latched result[17:3].
- result_tag  out  3  latched result[2:0].

Behaviour:
- Reset values:
  - uart_tx=1; tx_busy=0; overflow=0; dropped=0; other_writes=0; done=0; result_value=0; result_tag=0.
  - FIFO empty; transmitter state IDLE.
- Reset asserted mid-frame: uart_tx is 1 from the edge where reset is sampled, the FIFO is flushed, and no partial byte resumes afterwards.
- Accept rule: iowrite=1, ioaddr==PUTCHAR_ADDR, finish not yet latched → push iowd[7:0].
  - The entry is visible in the FIFO after the same edge.
  - iowd[14:8] is ignored.
- iowrite=1 with any other address: other_writes increments (saturating). No FIFO action.
- Full FIFO:
  - A push with no pop in the same cycle is dropped; overflow is set and dropped increments (saturating).
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Empty FIFO: no pop is issued; the transmitter stays IDLE.
- FIFO pointers are FIFO_LOG2+1 bits. Full/empty are decided by MSB-differs, lower-equal comparison. Pointers wrap naturally.
- Transmitter FSM states and transitions:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles. Then shift right and increment the index. After index 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency and timing:
  - For a write accepted at edge N into an empty, idle block, uart_tx goes low after edge N+1.
  - A full frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back bytes: IDLE lasts exactly one cycle between frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state change.
- finish:
  - On the first cycle with finish=1 (while not latched), latch result_value and result_tag and set the latched flag.
  - Later finish pulses are ignored until reset.
  - An iowrite to PUTCHAR_ADDR in the same cycle as the first finish is still accepted.
  - After the latch, all iowrites are ignored and not counted.
- done: registered. Asserts on the cycle after (latched && FIFO empty && IDLE) becomes true, and stays high until reset.
- tx_busy: registered, equal to (FIFO non-empty || state!=IDLE).

Decomposition:
- Shared include/package holds:
  - transmitter state encodings IO_TX_IDLE, IO_TX_START, IO_TX_DATA, IO_TX_STOP (2 bits);
  - the default PUTCHAR_ADDR;
  - the result payload/tag field positions (17:3, 2:0).
- One sub-module, uart_tx_8n1: holds the FSM, baud counter and shift register.
  - Interface: clock, reset, valid/ready byte input, uart_tx out, idle out.
- The top-level holds the FIFO, the address decode, the counters and the finish latch.

Test Plan:
- Single byte: CLKS_PER_BIT=4; reset; iowrite ioaddr=0 iowd=15'h041 at cycle 10 → uart_tx low from cycle 12 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high; tx_busy high cycles 11–51.
- Burst/full: 20 consecutive writes 0x30..0x43 with FIFO_LOG2=4 and no drain between → bytes 0x30..0x40 appear on the wire in order (16 queued plus 1 popped during the burst); overflow=1; dropped=3.
- Address filter: writes to ioaddr=5 (x3) and ioaddr=0 iowd=15'h7F5A (x1) → other_writes=3; exactly one frame carrying 0x5A.
- Finish/done: enqueue "HI" (0x48, 0x49), then finish=1 with result=18'h0015A → result_value=15'h002B, result_tag=3'd2; done rises one cycle after the second stop bit ends; later writes are ignored.
- Reset mid-frame: assert reset during DATA bit 3 → uart_tx=1 the next cycle; FIFO empty; counters 0; the next write transmits a clean full frame.
- Saturation: 300 writes to ioaddr=7 → other_writes=255.

Source files
------------

// File: rtl/reduceron_io_uart_pkg.sv
// Shared definitions for the Reduceron IO-to-UART console sink.
package reduceron_io_uart_pkg;

  typedef enum logic [1:0] {
    IO_TX_IDLE  = 2'd0,
    IO_TX_START = 2'd1,
    IO_TX_DATA  = 2'd2,
    IO_TX_STOP  = 2'd3
  } tx_state_t;

  localparam logic [14:0] PUTCHAR_ADDR_DEFAULT = 15'd0;

  localparam int RESULT_VALUE_MSB = 17;
  localparam int RESULT_VALUE_LSB = 3;
  localparam int RESULT_TAG_MSB   = 2;
  localparam int RESULT_TAG_LSB   = 0;

endpackage

// File: rtl/reduceron_io_uart_if.sv
// Reduceron core IO-write / finish port as seen by downstream sinks.
interface reduceron_io_uart_if;
  logic        iowrite;
  logic [14:0] ioaddr;
  logic [14:0] iowd;
  logic        finish;
  logic [17:0] result;

  modport master (output iowrite, ioaddr, iowd, finish, result);
  modport slave  (input  iowrite, ioaddr, iowd, finish, result);
endinterface

// File: rtl/reduceron_io_uart_tx.sv
// 8N1 serialiser: start bit, eight data bits LSB first, one stop bit.
module uart_tx_8n1
  import reduceron_io_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       uart_tx,
  output logic       idle,
  output logic       frame_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             last;

  assign last  = (cnt == CNT_LAST);
  assign ready = (state == IO_TX_IDLE);
  assign idle  = ready;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    idx_n     = idx;
    shift_n   = shift;
    frame_end = 1'b0;
    case (state)
      IO_TX_IDLE: begin
        cnt_n = '0;
        if (valid) begin
          shift_n = data;
          state_n = IO_TX_START;
        end
      end
      IO_TX_START: begin
        if (last) begin
          state_n = IO_TX_DATA;
          cnt_n   = '0;
          idx_n   = 3'd0;
        end
      end
      IO_TX_DATA: begin
        if (last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) state_n = IO_TX_STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      IO_TX_STOP: begin
        if (last) begin
          state_n   = IO_TX_IDLE;
          cnt_n     = '0;
          frame_end = 1'b1;
        end
      end
      default: state_n = IO_TX_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (state_n)
      IO_TX_START: tx_n = 1'b0;
      IO_TX_DATA:  tx_n = shift_n[0];
      default:     tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IO_TX_IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      uart_tx <= tx_n;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_n;
  end

endmodule

// File: rtl/reduceron_io_uart.sv
// Console sink: filters putchar writes into a FIFO, drains them over UART,
// and latches the core's final result.
module reduceron_io_uart
  import reduceron_io_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_LOG2    = 4,
  parameter logic [14:0] PUTCHAR_ADDR = PUTCHAR_ADDR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  reduceron_io_uart_if.slave    core,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  overflow,
  output logic [7:0]            dropped,
  output logic [7:0]            other_writes,
  output logic                  done,
  output logic [14:0]           result_value,
  output logic [2:0]            result_tag
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] PTR_ONE = (FIFO_LOG2 + 1)'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]         mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic               empty, full, latched;
  logic               put_hit, other_hit, push, pop, drop;
  logic               tx_ready, tx_idle, tx_frame_end, busy_n;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                 (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);

  assign put_hit   = core.iowrite && !latched && (core.ioaddr == PUTCHAR_ADDR);
  assign other_hit = core.iowrite && !latched && (core.ioaddr != PUTCHAR_ADDR);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = !empty && tx_ready;
  assign push = put_hit && (!full || pop);
  assign drop = put_hit && !push;

  assign wr_ptr_n = push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_n = pop  ? rd_ptr + PTR_ONE : rd_ptr;

  // Busy reflects the post-edge picture: queued bytes or a frame still on the wire.
  assign busy_n = (wr_ptr_n != rd_ptr_n) || pop || (!tx_idle && !tx_frame_end);

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock     (clock),
    .reset     (reset),
    .valid     (!empty),
    .data      (mem[rd_ptr[FIFO_LOG2-1:0]]),
    .ready     (tx_ready),
    .uart_tx   (uart_tx),
    .idle      (tx_idle),
    .frame_end (tx_frame_end)
  );

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[FIFO_LOG2-1:0]] <= core.iowd[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      dropped      <= 8'd0;
      other_writes <= 8'd0;
      latched      <= 1'b0;
      done         <= 1'b0;
      tx_busy      <= 1'b0;
      result_value <= 15'd0;
      result_tag   <= 3'd0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      tx_busy <= busy_n;
      if (drop) begin
        overflow <= 1'b1;
        dropped  <= sat_inc(dropped);
      end
      if (other_hit) other_writes <= sat_inc(other_writes);
      if (core.finish && !latched) begin
        latched      <= 1'b1;
        result_value <= core.result[RESULT_VALUE_MSB:RESULT_VALUE_LSB];
        result_tag   <= core.result[RESULT_TAG_MSB:RESULT_TAG_LSB];
      end
      done <= done || (latched && empty && tx_idle);
    end
  end

endmodule

// File: tb/tb_reduceron_io_uart.sv
// Directed bench for reduceron_io_uart at 4 clocks per bit and a 16-deep FIFO.
module tb_reduceron_io_uart;

  localparam int CPB = 4;
  localparam int FL  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_tx, tx_busy, overflow, done;
  logic [7:0]  dropped, other_writes;
  logic [14:0] result_value;
  logic [2:0]  result_tag;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reduceron_io_uart_if bus ();

  reduceron_io_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_LOG2    (FL),
    .PUTCHAR_ADDR (15'd0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .core         (bus),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy),
    .overflow     (overflow),
    .dropped      (dropped),
    .other_writes (other_writes),
    .done         (done),
    .result_value (result_value),
    .result_tag   (result_tag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.iowrite = 1'b0;
    bus.finish  = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [14:0] d);
    bus.iowrite = 1'b1;
    bus.ioaddr  = a;
    bus.iowd    = d;
    tick(1);
    bus.iowrite = 1'b0;
  endtask

  // Waits for a start bit and samples the frame at bit centres.
  task automatic rx_byte(output logic [7:0] b);
    int w;
    w = 0;
    b = 8'h00;
    while (uart_tx !== 1'b0 && w < 400) begin
      tick(1);
      w++;
    end
    chk("rx_start", {31'b0, uart_tx}, 32'd0);
    if (uart_tx !== 1'b0) return;
    tick(2);
    chk("rx_start_mid", {31'b0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(4);
      b[i] = uart_tx;
    end
    tick(4);
    chk("rx_stop", {31'b0, uart_tx}, 32'd1);
    tick(2);
  endtask

  task automatic quiet(input string tag, input int n);
    int lows;
    lows = 0;
    repeat (n) begin
      tick(1);
      if (uart_tx !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ch;
    logic       exp_bit;

    bus.iowrite = 1'b0;
    bus.ioaddr  = 15'd0;
    bus.iowd    = 15'd0;
    bus.finish  = 1'b0;
    bus.result  = 18'd0;
    reset       = 1'b1;

    // Reset state
    do_reset();
    chk("rst_tx", {31'b0, uart_tx}, 1);
    chk("rst_busy", {31'b0, tx_busy}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_dropped", {24'b0, dropped}, 0);
    chk("rst_other", {24'b0, other_writes}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_value", {17'b0, result_value}, 0);
    chk("rst_tag", {29'b0, result_tag}, 0);

    // Single byte with exact per-cycle waveform
    tick(3);
    wr(15'd0, 15'h041);
    chk("t1_busy_accept", {31'b0, tx_busy}, 1);
    chk("t1_tx_accept", {31'b0, uart_tx}, 1);
    ch = 8'h41;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (k < 4)       exp_bit = 1'b0;
      else if (k < 36) exp_bit = ch[(k - 4) / 4];
      else             exp_bit = 1'b1;
      chk($sformatf("t1_tx_c%0d", k), {31'b0, uart_tx}, {31'b0, exp_bit});
      chk($sformatf("t1_busy_c%0d", k), {31'b0, tx_busy}, 1);
    end
    tick(1);
    chk("t1_tx_after", {31'b0, uart_tx}, 1);
    chk("t1_busy_after", {31'b0, tx_busy}, 0);

    // Burst into a full FIFO
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) wr(15'd0, 15'(8'h30 + i));
      end
      begin
        logic [7:0] b;
        for (int j = 0; j < 17; j++) begin
          rx_byte(b);
          chk($sformatf("t2_byte%0d", j), {24'b0, b}, 32'(8'h30 + j));
        end
      end
    join
    chk("t2_overflow", {31'b0, overflow}, 1);
    chk("t2_dropped", {24'b0, dropped}, 3);
    chk("t2_busy_end", {31'b0, tx_busy}, 0);
    quiet("t2_no_extra_frame", 60);

    // Address filter
    do_reset();
    wr(15'd5, 15'h0011);
    wr(15'd5, 15'h0022);
    wr(15'd5, 15'h0033);
    wr(15'd0, 15'h7F5A);
    begin
      logic [7:0] b;
      rx_byte(b);
      chk("t3_byte", {24'b0, b}, 32'h5A);
    end
    chk("t3_other", {24'b0, other_writes}, 3);
    quiet("t3_no_extra_frame", 60);

    // Finish latch and done
    do_reset();
    fork
      begin
        wr(15'd0, 15'h0048);
        bus.iowrite = 1'b1;
        bus.ioaddr  = 15'd0;
        bus.iowd    = 15'h0049;
        bus.finish  = 1'b1;
        bus.result  = 18'h0015A;
        tick(1);
        bus.iowd    = 15'h0050;
        bus.result  = 18'h3FFFF;
        tick(1);
        bus.ioaddr  = 15'd5;
        bus.finish  = 1'b0;
        tick(1);
        bus.iowrite = 1'b0;
      end
      begin
        logic [7:0] b;
        rx_byte(b);
        chk("t4_byte0", {24'b0, b}, 32'h48);
        chk("t4_done_mid", {31'b0, done}, 0);
        rx_byte(b);
        chk("t4_byte1", {24'b0, b}, 32'h49);
        chk("t4_done_before", {31'b0, done}, 0);
        tick(1);
        chk("t4_done_rise", {31'b0, done}, 1);
      end
    join
    chk("t4_value", {17'b0, result_value}, 32'h002B);
    chk("t4_tag", {29'b0, result_tag}, 2);
    chk("t4_other", {24'b0, other_writes}, 0);
    quiet("t4_no_extra_frame", 60);
    chk("t4_done_sticky", {31'b0, done}, 1);

    // Reset during a data bit
    do_reset();
    wr(15'd0, 15'h00A5);
    wr(15'd9, 15'h0000);
    wr(15'd0, 15'h0011);
    wr(15'd0, 15'h0022);
    tick(15);
    chk("t5_tx_bit3", {31'b0, uart_tx}, 0);
    chk("t5_other_pre", {24'b0, other_writes}, 1);
    reset = 1'b1;
    tick(1);
    chk("t5_tx_reset", {31'b0, uart_tx}, 1);
    chk("t5_busy_reset", {31'b0, tx_busy}, 0);
    chk("t5_other_reset", {24'b0, other_writes}, 0);
    reset = 1'b0;
    quiet("t5_no_resume", 60);
    chk("t5_busy_idle", {31'b0, tx_busy}, 0);
    wr(15'd0, 15'h003C);
    begin
      logic [7:0] b;
      rx_byte(b);
      chk("t5_clean_byte", {24'b0, b}, 32'h3C);
    end

    // Counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) wr(15'd7, 15'(i));
    chk("t6_other_sat", {24'b0, other_writes}, 255);
    chk("t6_busy", {31'b0, tx_busy}, 0);
    chk("t6_overflow", {31'b0, overflow}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
